// File: rtl/seq_loop_monitor_if.sv
// Sequential-loop monitor bus: sampled DUT state, loop descriptors and report.
// master drives the loop descriptors, slave is the monitor.
interface seq_loop_monitor_if #(
    parameter int FSM_WIDTH = 2,
    parameter int CNT_WIDTH = 16
) ();
    logic [FSM_WIDTH-1:0] cur_state;
    logic [1:0]           pre_states_valid;
    logic [FSM_WIDTH-1:0] pre_loop_state0;
    logic [FSM_WIDTH-1:0] pre_loop_state1;
    logic [1:0]           post_states_valid;
    logic [FSM_WIDTH-1:0] post_loop_state0;
    logic [FSM_WIDTH-1:0] post_loop_state1;
    logic [FSM_WIDTH-1:0] loop_quit_state;
    logic [FSM_WIDTH-1:0] iter_start_state;
    logic                 iter_end_states_valid;
    logic [FSM_WIDTH-1:0] iter_end_state0;
    logic                 one_state_loop;
    logic                 finish;

    logic                 loop_active;
    logic [CNT_WIDTH-1:0] iter_count;
    logic                 rpt_valid;
    logic [CNT_WIDTH-1:0] rpt_iters;
    logic [CNT_WIDTH-1:0] rpt_cycles;
    logic                 rpt_sat;
    logic                 rpt_aborted;
    logic [CNT_WIDTH-1:0] loop_entries;
    logic                 done;
    logic [2:0]           err;

    modport master (
        output cur_state,
        output pre_states_valid,
        output pre_loop_state0,
        output pre_loop_state1,
        output post_states_valid,
        output post_loop_state0,
        output post_loop_state1,
        output loop_quit_state,
        output iter_start_state,
        output iter_end_states_valid,
        output iter_end_state0,
        output one_state_loop,
        output finish,
        input  loop_active,
        input  iter_count,
        input  rpt_valid,
        input  rpt_iters,
        input  rpt_cycles,
        input  rpt_sat,
        input  rpt_aborted,
        input  loop_entries,
        input  done,
        input  err
    );

    modport slave (
        input  cur_state,
        input  pre_states_valid,
        input  pre_loop_state0,
        input  pre_loop_state1,
        input  post_states_valid,
        input  post_loop_state0,
        input  post_loop_state1,
        input  loop_quit_state,
        input  iter_start_state,
        input  iter_end_states_valid,
        input  iter_end_state0,
        input  one_state_loop,
        input  finish,
        output loop_active,
        output iter_count,
        output rpt_valid,
        output rpt_iters,
        output rpt_cycles,
        output rpt_sat,
        output rpt_aborted,
        output loop_entries,
        output done,
        output err
    );
endinterface

// File: rtl/seq_loop_monitor.sv
// Sequential-loop monitor: tracks loop entry, iterations and exit of a DUT FSM.
// Optional protocol checks are built when SEQ_LOOP_MON_ERR_EN is defined.
module seq_loop_monitor #(
    parameter int FSM_WIDTH = 2,
    parameter int CNT_WIDTH = 16
) (
    input logic clock,
    input logic reset,
    seq_loop_monitor_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        FINISHED = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t state;
    state_t state_nxt;

    logic [FSM_WIDTH-1:0] prev_state;
    logic                 prev_ok;

    logic [CNT_WIDTH-1:0] iters;
    logic [CNT_WIDTH-1:0] iters_nxt;
    logic [CNT_WIDTH-1:0] cycles;
    logic [CNT_WIDTH-1:0] cycles_nxt;
    logic [CNT_WIDTH-1:0] entries;
    logic [CNT_WIDTH-1:0] entries_nxt;
    logic                 sat;
    logic                 sat_nxt;

    logic                 rpt_valid_r;
    logic                 rpt_valid_nxt;
    logic [CNT_WIDTH-1:0] rpt_iters_r;
    logic [CNT_WIDTH-1:0] rpt_iters_nxt;
    logic [CNT_WIDTH-1:0] rpt_cycles_r;
    logic [CNT_WIDTH-1:0] rpt_cycles_nxt;
    logic                 rpt_sat_r;
    logic                 rpt_sat_nxt;
    logic                 rpt_aborted_r;
    logic                 rpt_aborted_nxt;
    logic                 done_r;
    logic                 done_nxt;

    logic pre_hit;
    logic post_hit;
    logic entry;
    logic exit_seen;
    logic iter_end;

    logic [CNT_WIDTH-1:0] iters_step;
    logic [CNT_WIDTH-1:0] cycles_step;
    logic                 iters_ovf;
    logic                 cycles_ovf;

    // Decode loop transitions from the previous and current state samples
    always_comb begin
        pre_hit = prev_ok && (
            (bus.pre_states_valid[0]
             && prev_state == bus.pre_loop_state0) ||
            (bus.pre_states_valid[1]
             && prev_state == bus.pre_loop_state1));
        post_hit =
            (bus.post_states_valid[0]
             && bus.cur_state == bus.post_loop_state0) ||
            (bus.post_states_valid[1]
             && bus.cur_state == bus.post_loop_state1);
        entry = pre_hit
            && bus.cur_state == bus.iter_start_state;
        exit_seen = prev_ok
            && prev_state == bus.loop_quit_state
            && post_hit;
        iter_end =
            (bus.iter_end_states_valid
             && bus.cur_state == bus.iter_end_state0) ||
            (bus.one_state_loop
             && bus.cur_state == bus.iter_start_state);
    end

    // Saturating increments; an ovf flag means a count was clamped
    always_comb begin
        iters_ovf   = iter_end && (iters == CNT_MAX);
        cycles_ovf  = (cycles == CNT_MAX);
        iters_step  = iters;
        if (iter_end && !iters_ovf) begin
            iters_step = iters + CNT_ONE;
        end
        cycles_step = cycles_ovf ? cycles : cycles + CNT_ONE;
    end

    // Remember the last sampled state so transitions can be recognised
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_state <= '0;
            prev_ok    <= 1'b0;
        end else begin
            prev_state <= bus.cur_state;
            prev_ok    <= 1'b1;
        end
    end

    // Loop FSM next state, counters and report (finish > exit > entry)
    always_comb begin
        state_nxt       = state;
        iters_nxt       = iters;
        cycles_nxt      = cycles;
        entries_nxt     = entries;
        sat_nxt         = sat;
        rpt_valid_nxt   = 1'b0;
        rpt_iters_nxt   = rpt_iters_r;
        rpt_cycles_nxt  = rpt_cycles_r;
        rpt_sat_nxt     = rpt_sat_r;
        rpt_aborted_nxt = rpt_aborted_r;
        done_nxt        = done_r;
        unique case (state)
            IDLE: begin
                if (bus.finish) begin
                    state_nxt = FINISHED;
                    done_nxt  = 1'b1;
                end else if (entry) begin
                    state_nxt  = ACTIVE;
                    iters_nxt  = iter_end ? CNT_ONE : '0;
                    cycles_nxt = CNT_ONE;
                    sat_nxt    = 1'b0;
                    if (entries != CNT_MAX) begin
                        entries_nxt = entries + CNT_ONE;
                    end
                end
            end
            ACTIVE: begin
                if (bus.finish) begin
                    state_nxt       = FINISHED;
                    done_nxt        = 1'b1;
                    iters_nxt       = iters_step;
                    cycles_nxt      = cycles_step;
                    sat_nxt         = sat | iters_ovf | cycles_ovf;
                    rpt_valid_nxt   = 1'b1;
                    rpt_iters_nxt   = iters_step;
                    rpt_cycles_nxt  = cycles_step;
                    rpt_sat_nxt     = sat | iters_ovf | cycles_ovf;
                    rpt_aborted_nxt = 1'b1;
                end else if (exit_seen) begin
                    state_nxt       = IDLE;
                    rpt_valid_nxt   = 1'b1;
                    rpt_iters_nxt   = iters;
                    rpt_cycles_nxt  = cycles;
                    rpt_sat_nxt     = sat;
                    rpt_aborted_nxt = 1'b0;
                end else begin
                    iters_nxt  = iters_step;
                    cycles_nxt = cycles_step;
                    sat_nxt    = sat | iters_ovf | cycles_ovf;
                end
            end
            FINISHED: begin
                done_nxt = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Loop FSM and report registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            iters         <= '0;
            cycles        <= '0;
            entries       <= '0;
            sat           <= 1'b0;
            rpt_valid_r   <= 1'b0;
            rpt_iters_r   <= '0;
            rpt_cycles_r  <= '0;
            rpt_sat_r     <= 1'b0;
            rpt_aborted_r <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state         <= state_nxt;
            iters         <= iters_nxt;
            cycles        <= cycles_nxt;
            entries       <= entries_nxt;
            sat           <= sat_nxt;
            rpt_valid_r   <= rpt_valid_nxt;
            rpt_iters_r   <= rpt_iters_nxt;
            rpt_cycles_r  <= rpt_cycles_nxt;
            rpt_sat_r     <= rpt_sat_nxt;
            rpt_aborted_r <= rpt_aborted_nxt;
            done_r        <= done_nxt;
        end
    end

    assign bus.loop_active  = (state == ACTIVE);
    assign bus.iter_count   = iters;
    assign bus.rpt_valid    = rpt_valid_r;
    assign bus.rpt_iters    = rpt_iters_r;
    assign bus.rpt_cycles   = rpt_cycles_r;
    assign bus.rpt_sat      = rpt_sat_r;
    assign bus.rpt_aborted  = rpt_aborted_r;
    assign bus.loop_entries = entries;
    assign bus.done         = done_r;

`ifdef SEQ_LOOP_MON_ERR_EN
    logic [2:0] err_flags;

    // Sticky flags for loop events seen in a state where they make no sense
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_flags <= 3'b000;
        end else begin
            if (entry && state == ACTIVE) begin
                err_flags[0] <= 1'b1;
            end
            if (exit_seen && state == IDLE) begin
                err_flags[1] <= 1'b1;
            end
            if (iter_end && !entry && state == IDLE) begin
                err_flags[2] <= 1'b1;
            end
        end
    end

    assign bus.err = err_flags;
`else
    assign bus.err = 3'b000;
`endif

endmodule

// File: tb/tb_seq_loop_monitor.sv
// Testbench for seq_loop_monitor: directed loop scenarios plus random
// state streams checked against an unbounded-count reference model.
module tb_seq_loop_monitor;
    localparam int FW   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    seq_loop_monitor_if #(.FSM_WIDTH(FW), .CNT_WIDTH(CW)) bus ();

    seq_loop_monitor #(.FSM_WIDTH(FW), .CNT_WIDTH(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // reference model: 0 = idle, 1 = in loop, 2 = finished
    int          m_mode;
    bit          m_prev_ok;
    logic [FW-1:0] m_prev;
    int          raw_it;
    int          raw_cyc;
    int          m_entries;
    bit          e_rpt_valid;
    int          e_rpt_iters;
    int          e_rpt_cycles;
    bit          e_rpt_sat;
    bit          e_rpt_aborted;
    bit          e_done;
    logic [2:0]  e_err;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_reset();
        m_mode        = 0;
        m_prev_ok     = 1'b0;
        m_prev        = '0;
        raw_it        = 0;
        raw_cyc       = 0;
        m_entries     = 0;
        e_rpt_valid   = 1'b0;
        e_rpt_iters   = 0;
        e_rpt_cycles  = 0;
        e_rpt_sat     = 1'b0;
        e_rpt_aborted = 1'b0;
        e_done        = 1'b0;
        e_err         = 3'b000;
    endtask

    task automatic model_report(input bit aborted);
        e_rpt_valid   = 1'b1;
        e_rpt_iters   = clamp(raw_it);
        e_rpt_cycles  = clamp(raw_cyc);
        e_rpt_sat     = (raw_it > CMAX) || (raw_cyc > CMAX);
        e_rpt_aborted = aborted;
    endtask

    task automatic model_step();
        logic [FW-1:0] c;
        bit pre_h, post_h, ent, ext, ie;
        c = bus.cur_state;
        pre_h = m_prev_ok &&
            ((bus.pre_states_valid[0] && m_prev == bus.pre_loop_state0) ||
             (bus.pre_states_valid[1] && m_prev == bus.pre_loop_state1));
        post_h =
            (bus.post_states_valid[0] && c == bus.post_loop_state0) ||
            (bus.post_states_valid[1] && c == bus.post_loop_state1);
        ent = pre_h && (c == bus.iter_start_state);
        ext = m_prev_ok && (m_prev == bus.loop_quit_state) && post_h;
        ie  = (bus.iter_end_states_valid && c == bus.iter_end_state0) ||
              (bus.one_state_loop && c == bus.iter_start_state);
`ifdef SEQ_LOOP_MON_ERR_EN
        if (m_mode == 1 && ent) e_err[0] = 1'b1;
        if (m_mode == 0 && ext) e_err[1] = 1'b1;
        if (m_mode == 0 && ie && !ent) e_err[2] = 1'b1;
`endif
        e_rpt_valid = 1'b0;
        if (m_mode == 2) begin
            e_done = 1'b1;
        end else if (bus.finish) begin
            if (m_mode == 1) begin
                raw_cyc++;
                if (ie) raw_it++;
                model_report(1'b1);
            end
            m_mode = 2;
            e_done = 1'b1;
        end else if (m_mode == 1) begin
            if (ext) begin
                model_report(1'b0);
                m_mode = 0;
            end else begin
                raw_cyc++;
                if (ie) raw_it++;
            end
        end else if (ent) begin
            m_mode  = 1;
            raw_cyc = 1;
            raw_it  = ie ? 1 : 0;
            m_entries++;
        end
        m_prev    = c;
        m_prev_ok = 1'b1;
    endtask

    task automatic compare_all();
        chk("loop_active", 32'(bus.loop_active), 32'(m_mode == 1));
        chk("iter_count", 32'(bus.iter_count), clamp(raw_it));
        chk("rpt_valid", 32'(bus.rpt_valid), 32'(e_rpt_valid));
        chk("rpt_iters", 32'(bus.rpt_iters), e_rpt_iters);
        chk("rpt_cycles", 32'(bus.rpt_cycles), e_rpt_cycles);
        chk("rpt_sat", 32'(bus.rpt_sat), 32'(e_rpt_sat));
        chk("rpt_aborted", 32'(bus.rpt_aborted), 32'(e_rpt_aborted));
        chk("loop_entries", 32'(bus.loop_entries), clamp(m_entries));
        chk("done", 32'(bus.done), 32'(e_done));
        chk("err", 32'(bus.err), 32'(e_err));
    endtask

    task automatic step(input int st, input bit fin);
        bus.cur_state = FW'(st);
        bus.finish    = fin;
        @(posedge clock);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic set_desc(input int p0, input int st, input int en,
                            input int qt, input int po, input bit osl);
        bus.pre_states_valid      = 2'b01;
        bus.pre_loop_state0       = FW'(p0);
        bus.pre_loop_state1       = '0;
        bus.post_states_valid     = 2'b01;
        bus.post_loop_state0      = FW'(po);
        bus.post_loop_state1      = '0;
        bus.loop_quit_state       = FW'(qt);
        bus.iter_start_state      = FW'(st);
        bus.iter_end_states_valid = 1'b1;
        bus.iter_end_state0       = FW'(en);
        bus.one_state_loop        = osl;
    endtask

    task automatic run_seq(input int seq[$]);
        foreach (seq[i]) step(seq[i], 1'b0);
    endtask

    initial begin
        bus.cur_state = '0;
        bus.finish    = 1'b0;
        set_desc(0, 1, 2, 2, 3, 1'b0);
        model_reset();

        // basic two-iteration loop
        do_reset();
        run_seq('{0, 1, 2, 1, 2, 3});
        chk("s1_rpt_valid", 32'(bus.rpt_valid), 1);
        chk("s1_rpt_iters", 32'(bus.rpt_iters), 2);
        chk("s1_rpt_cycles", 32'(bus.rpt_cycles), 4);
        chk("s1_entries", 32'(bus.loop_entries), 1);
        step(0, 1'b0);
        chk("s1_pulse_once", 32'(bus.rpt_valid), 0);

        // one-state loop
        set_desc(0, 1, 1, 1, 3, 1'b1);
        do_reset();
        run_seq('{0, 1, 1, 1, 3});
        chk("s2_rpt_iters", 32'(bus.rpt_iters), 3);
        chk("s2_rpt_cycles", 32'(bus.rpt_cycles), 3);

        // finish on the third active cycle
        set_desc(0, 1, 2, 2, 3, 1'b0);
        do_reset();
        run_seq('{0, 1, 2});
        step(1, 1'b1);
        chk("s3_rpt_valid", 32'(bus.rpt_valid), 1);
        chk("s3_aborted", 32'(bus.rpt_aborted), 1);
        chk("s3_rpt_cycles", 32'(bus.rpt_cycles), 3);
        run_seq('{0, 1, 2, 1});
        chk("s3_done", 32'(bus.done), 1);
        chk("s3_no_active", 32'(bus.loop_active), 0);
        chk("s3_entries", 32'(bus.loop_entries), 1);

        // saturation after 20 iterations, next loop clean
        do_reset();
        run_seq('{0, 1});
        for (int i = 0; i < 19; i++) run_seq('{2, 1});
        run_seq('{2, 3});
        chk("s4_rpt_iters", 32'(bus.rpt_iters), 15);
        chk("s4_rpt_sat", 32'(bus.rpt_sat), 1);
        run_seq('{0, 1, 2, 3});
        chk("s4_next_iters", 32'(bus.rpt_iters), 1);
        chk("s4_next_sat", 32'(bus.rpt_sat), 0);

        // reset released as the state moves 0 -> 1
        bus.cur_state = 2'd0;
        do_reset();
        step(1, 1'b0);
        chk("s5_active", 32'(bus.loop_active), 0);
        step(1, 1'b0);
        chk("s5_entries", 32'(bus.loop_entries), 0);

        // reset in the middle of a loop
        do_reset();
        run_seq('{0, 1, 2});
        chk("s6_active", 32'(bus.loop_active), 1);
        do_reset();
        chk("s6_cleared", 32'(bus.loop_active), 0);

        // protocol errors from IDLE
        bus.cur_state = 2'd2;
        do_reset();
        run_seq('{2, 3});
`ifdef SEQ_LOOP_MON_ERR_EN
        chk("s7_err", 32'(bus.err), 32'h6);
`else
        chk("s7_err", 32'(bus.err), 0);
`endif

        // random descriptors and state streams
        for (int k = 0; k < 40; k++) begin
            bus.pre_states_valid      = 2'($urandom_range(1, 3));
            bus.pre_loop_state0       = FW'($urandom_range(0, 3));
            bus.pre_loop_state1       = FW'($urandom_range(0, 3));
            bus.post_states_valid     = 2'($urandom_range(1, 3));
            bus.post_loop_state0      = FW'($urandom_range(0, 3));
            bus.post_loop_state1      = FW'($urandom_range(0, 3));
            bus.loop_quit_state       = FW'($urandom_range(0, 3));
            bus.iter_start_state      = FW'($urandom_range(0, 3));
            bus.iter_end_states_valid = 1'($urandom_range(0, 1));
            bus.iter_end_state0       = FW'($urandom_range(0, 3));
            bus.one_state_loop        = 1'($urandom_range(0, 1));
            do_reset();
            for (int c = 0; c < 28; c++) begin
                step(int'($urandom_range(0, 3)),
                     $urandom_range(0, 49) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/seq_loop_monitor.md
# seq_loop_monitor

Simulation-side monitor that sits directly downstream of the sequential-loop interface. Each clock it samples the DUT's FSM state and the loop-descriptor signals (pre/post/quit/iteration states, one-state flags, finish), detects loop entry, iteration completion and loop exit, and keeps iteration and cycle counts. It emits one registered report per loop execution for the scoreboard and coverage collectors.

## Interface
- `FSM_WIDTH`, 2, width of all FSM state fields
- `CNT_WIDTH`, 16, width of the iteration and cycle counters
- `clock` in 1: sampling clock
- `reset` in 1: reset, asynchronous, active-low
- `cur_state` in FSM_WIDTH: DUT FSM state this cycle
- `pre_states_valid` in 2: valid bits for `pre_loop_state0/1`
- `pre_loop_state0`, `pre_loop_state1` in FSM_WIDTH: states from which the loop is entered
- `post_states_valid` in 2: valid bits for `post_loop_state0/1`
- `post_loop_state0`, `post_loop_state1` in FSM_WIDTH: states reached on loop exit
- `loop_quit_state` in FSM_WIDTH: state from which the loop exits
- `iter_start_state` in FSM_WIDTH: first state of an iteration
- `iter_end_states_valid` in 1: valid for `iter_end_state0`
- `iter_end_state0` in FSM_WIDTH: last state of an iteration
- `one_state_loop` in 1: loop body is a single state
- `finish` in 1: DUT run complete
- `loop_active` out 1: monitor is inside a loop
- `iter_count` out CNT_WIDTH: iterations completed in the current/last loop
- `rpt_valid` out 1: one-cycle report pulse
- `rpt_iters` out CNT_WIDTH: iterations in the reported loop
- `rpt_cycles` out CNT_WIDTH: cycles spent in the reported loop
- `rpt_sat` out 1: a counter saturated during the reported loop
- `rpt_aborted` out 1: loop terminated by `finish`, not by exit
- `loop_entries` out CNT_WIDTH: total loop entries since reset (saturating)
- `done` out 1: `finish` seen (sticky)
- `err` out 3: protocol error flags, sticky (see Configuration)

## Operation
- `prev_state` register plus `prev_ok` flag. `prev_ok` = 0 at reset and 1 after the first sampled cycle. No transition is detected while `prev_ok` = 0.
- `pre_hit`: `prev_state` equals some valid `pre_loop_stateN`. `post_hit`: `cur_state` equals some valid `post_loop_stateN`.
- Entry: `pre_hit` && `cur_state == iter_start_state`.
- Exit: `prev_state == loop_quit_state` && `post_hit`.
- Iteration end: `iter_end_states_valid` && `cur_state == iter_end_state0`. When `one_state_loop` = 1, every ACTIVE cycle in `iter_start_state` counts, including the entry cycle.
- FSM states: IDLE, ACTIVE, FINISHED.
  - IDLE → ACTIVE on entry. Load `iter_count` = (entry cycle is an iteration end ? 1 : 0) and cycles = 1. Increment `loop_entries`.
  - ACTIVE, no exit: cycles += 1. `iter_count` += 1 on each iteration end.
  - ACTIVE → IDLE on exit. Pulse `rpt_*` with `rpt_aborted` = 0. The exit cycle is not counted.
  - Any state → FINISHED when `finish` = 1. If the FSM was ACTIVE, pulse a report with `rpt_aborted` = 1 that includes the current cycle.
  - FINISHED is absorbing until reset. `done` = 1.
- Priority: `finish` > exit > entry. Entry is ignored while ACTIVE.
- Counters saturate at all-ones and set the sticky per-loop `sat` bit, which is cleared on entry.
- `iter_count` holds its last value in IDLE.

## Timing
- All outputs are registered. A report appears the cycle after the exit or finish sample.
- `loop_active` rises the cycle after the entry sample and falls the cycle after the exit sample.
- `rpt_valid` is high for exactly one cycle. `rpt_*` hold their values until the next report.
- Reset values: every output = 0, FSM = IDLE, `prev_ok` = 0.
- Reset assertion mid-loop clears everything immediately. No report is emitted.

## Configuration
- `SEQ_LOOP_MON_ERR_EN` defined: protocol checks are active.
  - `err[0]`: entry seen while ACTIVE.
  - `err[1]`: exit seen while IDLE.
  - `err[2]`: iteration end seen while IDLE and not on an entry cycle.
  - Flags are sticky until reset.
- `SEQ_LOOP_MON_ERR_EN` undefined: `err` is tied to 0 and the check logic is absent.

## Test plan
- Setup for the first scenario: FSM_WIDTH=2, pre0=0, start=1, end0=2, quit=2, post0=3.
  - Stimulus: state sequence 0,1,2,1,2,3.
  - Response: `rpt_valid` pulses once with `rpt_iters`=2, `rpt_cycles`=4, `loop_entries`=1.
- One-state loop: `one_state_loop`=1, start=end=quit=1. Sequence 0,1,1,1,3 → `rpt_iters`=3, `rpt_cycles`=3.
- `finish` asserted on the 3rd ACTIVE cycle → report with `rpt_aborted`=1, `rpt_cycles`=3. `done` stays 1 and later entries are ignored.
- CNT_WIDTH=4, loop running 20 iterations → `rpt_iters`=15, `rpt_sat`=1. The next loop reports `rpt_sat`=0.
- Reset deasserted on the cycle the state goes 0 → 1 → no entry detected, `loop_active` stays 0.
- With `SEQ_LOOP_MON_ERR_EN` defined: sequence 2,3 from IDLE → `err`=3'b110. Without the macro: `err`=0.
